// File: rtl/pifo_sched_pkg.sv
// Default geometry and small helpers for the PIFO scheduler controller.
package pifo_sched_pkg;

   localparam int ELEMENT_BITS  = 3;
   localparam int PRIORITY_BITS = 4;

   // Index width that never collapses to zero bits for a single-entry range.
   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int NUMIN_DEF   = 4;
   localparam int NUMPORT_DEF = 2;
   localparam int CAP_DEF     = 2 ** ELEMENT_BITS;
   localparam int BITPRIO_DEF = PRIORITY_BITS;
   localparam int BITDATA_DEF = $clog2(CAP_DEF);
   localparam int BITPORT_DEF = clog2_min1(NUMPORT_DEF);

endpackage

// File: rtl/pifo_sched_ctrl_rr_pick.sv
// rr_pick: find the first set request at or after ptr, wrapping modulo N.
module rr_pick
   import pifo_sched_pkg::*;
#(
   parameter int N = 4,
   parameter int W = clog2_min1(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic         vld,
   output logic [W-1:0] idx
);

   logic [W-1:0] cand;

   // Walk the candidates in rotated order; the first hit wins and later hits are ignored.
   always_comb begin
      vld  = 1'b0;
      idx  = {W{1'b0}};
      cand = {W{1'b0}};
      for (int k = 0; k < N; k++) begin
         cand = W'((int'(ptr) + k) % N);
         idx  = (!vld && req[cand]) ? cand : idx;
         vld  = vld | req[cand];
      end
   end

endmodule

// File: rtl/pifo_sched_ctrl.sv
// pifo_sched_ctrl: two-lane round-robin enqueue into a PIFO, per-port
// round-robin dequeue with a one-cycle pop result, occupancy tracking and a
// sticky error for pop/result handshake violations.
module pifo_sched_ctrl
   import pifo_sched_pkg::*;
#(
   parameter int NUMIN   = NUMIN_DEF,
   parameter int NUMPORT = NUMPORT_DEF,
   parameter int CAP     = CAP_DEF,
   parameter int BITPRIO = BITPRIO_DEF,
   parameter int BITDATA = $clog2(CAP),
   parameter int BITPORT = clog2_min1(NUMPORT)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUMIN-1:0]           in_vld,
   output logic [NUMIN-1:0]           in_rdy,
   input  logic [NUMIN*BITPORT-1:0]   in_prt,
   input  logic [NUMIN*BITPRIO-1:0]   in_pri,
   input  logic [NUMIN*BITDATA-1:0]   in_dat,
   input  logic [NUMPORT-1:0]         deq_req,
   output logic                       deq_vld,
   output logic [BITPORT-1:0]         deq_prt,
   output logic [BITPRIO-1:0]         deq_pri,
   output logic [BITDATA-1:0]         deq_dat,
   output logic                       push_1,
   output logic [BITPORT-1:0]         uprt_1,
   output logic [BITPRIO-1:0]         upri_1,
   output logic [BITDATA-1:0]         udin_1,
   output logic                       push_2,
   output logic [BITPORT-1:0]         uprt_2,
   output logic [BITPRIO-1:0]         upri_2,
   output logic [BITDATA-1:0]         udin_2,
   output logic                       pop_0,
   output logic [BITPORT-1:0]         oprt_0,
   input  logic                       ovld_0,
   input  logic [BITPRIO-1:0]         opri_0,
   input  logic [BITDATA-1:0]         odout_0,
   output logic [$clog2(CAP):0]       occ,
   output logic                       err
);

   localparam int BITIN = clog2_min1(NUMIN);
   localparam int OCCW  = $clog2(CAP) + 1;

   // Architectural state
   logic [BITIN-1:0]   enq_ptr;
   logic [BITPORT-1:0] deq_ptr;
   logic [OCCW-1:0]    pcnt [NUMPORT];
   logic               pop_pend;
   logic [BITPORT-1:0] pop_prt;

   // Per-requester views of the flattened request fields
   logic [BITPORT-1:0] prt_a [NUMIN];
   logic [BITPRIO-1:0] pri_a [NUMIN];
   logic [BITDATA-1:0] dat_a [NUMIN];

   // Enqueue arbitration
   logic               g1_vld;
   logic               g2_vld;
   logic [BITIN-1:0]   g1_idx;
   logic [BITIN-1:0]   g2_idx;
   logic [NUMIN-1:0]   g2_req;
   logic [OCCW-1:0]    room;
   logic               allow_1;
   logic               allow_2;
   logic [BITIN-1:0]   last_idx;
   logic [BITIN-1:0]   enq_ptr_nxt;

   // Dequeue arbitration
   logic [NUMPORT-1:0] elig;
   logic               pop_hit;
   logic [BITPORT-1:0] pop_idx;
   logic [BITPORT-1:0] deq_ptr_nxt;

   // Next-state values
   logic [OCCW-1:0]    pcnt_nxt [NUMPORT];
   logic [OCCW-1:0]    occ_nxt;
   logic               err_nxt;

   // Split the flattened request buses into per-requester arrays.
   always_comb begin
      for (int i = 0; i < NUMIN; i++) begin
         prt_a[i] = in_prt[i*BITPORT +: BITPORT];
         pri_a[i] = in_pri[i*BITPRIO +: BITPRIO];
         dat_a[i] = in_dat[i*BITDATA +: BITDATA];
      end
   end

   rr_pick #(.N(NUMIN), .W(BITIN)) u_pick_enq1 (
      .req (in_vld),
      .ptr (enq_ptr),
      .vld (g1_vld),
      .idx (g1_idx)
   );

   // Mask the first winner so the second picker yields the next requester in rotation.
   always_comb begin
      g2_req = in_vld & ~(NUMIN'(1'b1) << g1_idx);
   end

   rr_pick #(.N(NUMIN), .W(BITIN)) u_pick_enq2 (
      .req (g2_req),
      .ptr (enq_ptr),
      .vld (g2_vld),
      .idx (g2_idx)
   );

   // Cap grants by free space and drive both push lanes from the winners' fields.
   always_comb begin
      room    = OCCW'(CAP) - occ;
      allow_1 = (room != {OCCW{1'b0}});
      allow_2 = (room >= OCCW'(2'd2));
      push_1  = !rst && g1_vld && allow_1;
      push_2  = !rst && g2_vld && allow_2 && push_1;
      uprt_1  = prt_a[g1_idx];
      upri_1  = pri_a[g1_idx];
      udin_1  = dat_a[g1_idx];
      uprt_2  = prt_a[g2_idx];
      upri_2  = pri_a[g2_idx];
      udin_2  = dat_a[g2_idx];
      in_rdy  = ({NUMIN{push_1}} & (NUMIN'(1'b1) << g1_idx))
              | ({NUMIN{push_2}} & (NUMIN'(1'b1) << g2_idx));
   end

   // Advance the enqueue pointer past the last requester granted this cycle.
   always_comb begin
      last_idx = push_2 ? g2_idx : g1_idx;
      if (!push_1) begin
         enq_ptr_nxt = enq_ptr;
      end else if (int'(last_idx) == NUMIN - 1) begin
         enq_ptr_nxt = {BITIN{1'b0}};
      end else begin
         enq_ptr_nxt = last_idx + BITIN'(1'b1);
      end
   end

   // A port may pop only on its registered count, so same-cycle pushes never qualify it.
   always_comb begin
      for (int p = 0; p < NUMPORT; p++) begin
         elig[p] = deq_req[p] && (pcnt[p] != {OCCW{1'b0}});
      end
   end

   rr_pick #(.N(NUMPORT), .W(BITPORT)) u_pick_pop (
      .req (elig),
      .ptr (deq_ptr),
      .vld (pop_hit),
      .idx (pop_idx)
   );

   // Issue at most one pop per cycle and step the dequeue pointer past the chosen port.
   always_comb begin
      pop_0  = !rst && pop_hit;
      oprt_0 = pop_idx;
      if (!pop_0) begin
         deq_ptr_nxt = deq_ptr;
      end else if (int'(pop_idx) == NUMPORT - 1) begin
         deq_ptr_nxt = {BITPORT{1'b0}};
      end else begin
         deq_ptr_nxt = pop_idx + BITPORT'(1'b1);
      end
   end

   // Per-port counts take both push lanes and the pop in the same cycle.
   always_comb begin
      for (int p = 0; p < NUMPORT; p++) begin
         pcnt_nxt[p] = pcnt[p]
                     + OCCW'(push_1 && (uprt_1 == BITPORT'(p)))
                     + OCCW'(push_2 && (uprt_2 == BITPORT'(p)))
                     - OCCW'(pop_0  && (oprt_0 == BITPORT'(p)));
      end
   end

   // Occupancy drops only when a result returns; error flags any pop/result mismatch.
   always_comb begin
      occ_nxt = occ + OCCW'(push_1) + OCCW'(push_2)
              - OCCW'(ovld_0 && (occ != {OCCW{1'b0}}));
      err_nxt = err | (pop_pend ^ ovld_0);
   end

   // The PIFO result arrives one cycle after the pop; reset suppresses it.
   always_comb begin
      deq_vld = !rst && pop_pend && ovld_0;
      deq_prt = pop_prt;
      deq_pri = opri_0;
      deq_dat = odout_0;
   end

   // State update with synchronous reset clearing every counter, pointer and flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         enq_ptr  <= {BITIN{1'b0}};
         deq_ptr  <= {BITPORT{1'b0}};
         pop_pend <= 1'b0;
         pop_prt  <= {BITPORT{1'b0}};
         occ      <= {OCCW{1'b0}};
         err      <= 1'b0;
         for (int p = 0; p < NUMPORT; p++) begin
            pcnt[p] <= {OCCW{1'b0}};
         end
      end else begin
         enq_ptr  <= enq_ptr_nxt;
         deq_ptr  <= deq_ptr_nxt;
         pop_pend <= pop_0;
         pop_prt  <= oprt_0;
         occ      <= occ_nxt;
         err      <= err_nxt;
         for (int p = 0; p < NUMPORT; p++) begin
            pcnt[p] <= pcnt_nxt[p];
         end
      end
   end

endmodule

// File: tb/tb_pifo_sched_ctrl.sv
// Directed bench for pifo_sched_ctrl with a behavioural one-cycle PIFO.
module tb_pifo_sched_ctrl;
   import pifo_sched_pkg::*;

   localparam int NI = 4;
   localparam int NP = 2;
   localparam int CP = 8;
   localparam int BP = 1;
   localparam int BR = 4;
   localparam int BD = 3;

   logic           clk = 1'b0;
   logic           rst;
   logic [NI-1:0]  in_vld;
   logic [NI-1:0]  in_rdy;
   logic [NI*BP-1:0] in_prt;
   logic [NI*BR-1:0] in_pri;
   logic [NI*BD-1:0] in_dat;
   logic [NP-1:0]  deq_req;
   logic           deq_vld;
   logic [BP-1:0]  deq_prt;
   logic [BR-1:0]  deq_pri;
   logic [BD-1:0]  deq_dat;
   logic           push_1, push_2, pop_0, ovld_0, err;
   logic [BP-1:0]  uprt_1, uprt_2, oprt_0;
   logic [BR-1:0]  upri_1, upri_2, opri_0;
   logic [BD-1:0]  udin_1, udin_2, odout_0;
   logic [3:0]     occ;
   logic           force_lo;

   int tests = 0;
   int fails = 0;

   pifo_sched_ctrl #(
      .NUMIN(NI), .NUMPORT(NP), .CAP(CP), .BITPRIO(BR), .BITDATA(BD), .BITPORT(BP)
   ) dut (
      .clk(clk), .rst(rst),
      .in_vld(in_vld), .in_rdy(in_rdy), .in_prt(in_prt), .in_pri(in_pri), .in_dat(in_dat),
      .deq_req(deq_req), .deq_vld(deq_vld), .deq_prt(deq_prt), .deq_pri(deq_pri), .deq_dat(deq_dat),
      .push_1(push_1), .uprt_1(uprt_1), .upri_1(upri_1), .udin_1(udin_1),
      .push_2(push_2), .uprt_2(uprt_2), .upri_2(upri_2), .udin_2(udin_2),
      .pop_0(pop_0), .oprt_0(oprt_0), .ovld_0(ovld_0), .opri_0(opri_0), .odout_0(odout_0),
      .occ(occ), .err(err)
   );

   always #5 clk = ~clk;

   // Behavioural PIFO: lowest rank per port first, ties by insertion order.
   logic          m_vld [CP];
   logic [BP-1:0] m_prt [CP];
   logic [BR-1:0] m_pri [CP];
   logic [BD-1:0] m_dat [CP];
   int            m_seq [CP];
   int            seq_ctr;
   int            mb, mf1, mf2;

   function automatic int find_min(input logic [BP-1:0] p);
      int best = -1;
      for (int i = 0; i < CP; i++) begin
         if (m_vld[i] && m_prt[i] == p) begin
            if (best < 0 || m_pri[i] < m_pri[best] ||
                (m_pri[i] == m_pri[best] && m_seq[i] < m_seq[best])) best = i;
         end
      end
      return best;
   endfunction

   function automatic int find_free(input int skip);
      for (int i = 0; i < CP; i++) begin
         if (!m_vld[i] && i != skip) return i;
      end
      return -1;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < CP; i++) m_vld[i] <= 1'b0;
         ovld_0  <= 1'b0;
         opri_0  <= '0;
         odout_0 <= '0;
         seq_ctr <= 0;
      end else begin
         mb  = find_min(oprt_0);
         mf1 = find_free(-1);
         mf2 = find_free(mf1);
         ovld_0 <= pop_0 && (mb >= 0) && !force_lo;
         if (pop_0 && mb >= 0) begin
            opri_0    <= m_pri[mb];
            odout_0   <= m_dat[mb];
            m_vld[mb] <= 1'b0;
         end
         if (push_1 && mf1 >= 0) begin
            m_vld[mf1] <= 1'b1; m_prt[mf1] <= uprt_1; m_pri[mf1] <= upri_1;
            m_dat[mf1] <= udin_1; m_seq[mf1] <= seq_ctr;
         end
         if (push_2 && mf2 >= 0) begin
            m_vld[mf2] <= 1'b1; m_prt[mf2] <= uprt_2; m_pri[mf2] <= upri_2;
            m_dat[mf2] <= udin_2; m_seq[mf2] <= seq_ctr + 1;
         end
         seq_ctr <= seq_ctr + 2;
      end
   end

   typedef struct {
      logic [3:0] vld;  logic [3:0] prt;  logic [1:0] deq;
      logic [3:0] rdy;  logic p1;  logic p2;  logic [3:0] pri1;  logic [3:0] pri2;
      logic pop;  logic oprt;  logic dvld;  logic [3:0] dpri;  logic [3:0] occ;
   } vec_t;
   vec_t vecs [9];

   logic [3:0] got_pri [8];
   logic [2:0] got_dat [8];
   logic       got_prt [8];
   logic       pop_seen [5];
   logic       pop_port [5];
   int         n_res;
   int         xfers;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; in_vld = '0; deq_req = '0; force_lo = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic push0(input logic [3:0] pri, input logic [2:0] dat);
      in_vld = 4'b0001; in_prt = 4'b0000;
      in_pri = {12'h000, pri}; in_dat = {9'h000, dat};
      #1;
      check("push0 rdy", in_rdy, 32'd1);
      tick();
      in_vld = 4'b0000;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      //         vld      prt      deq    rdy      p1    p2    pri1  pri2  pop   oprt  dvld  dpri  occ
      vecs[0] = '{4'b0101, 4'b0000, 2'b00, 4'b0101, 1'b1, 1'b1, 4'd1, 4'd3, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0};
      vecs[1] = '{4'b0000, 4'b0000, 2'b00, 4'b0000, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd2};
      vecs[2] = '{4'b0011, 4'b0010, 2'b00, 4'b0011, 1'b1, 1'b1, 4'd1, 4'd2, 1'b0, 1'b0, 1'b0, 4'd0, 4'd2};
      vecs[3] = '{4'b1000, 4'b0000, 2'b00, 4'b1000, 1'b1, 1'b0, 4'd4, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd4};
      vecs[4] = '{4'b1111, 4'b0000, 2'b00, 4'b0011, 1'b1, 1'b1, 4'd1, 4'd2, 1'b0, 1'b0, 1'b0, 4'd0, 4'd5};
      vecs[5] = '{4'b1111, 4'b0000, 2'b00, 4'b0100, 1'b1, 1'b0, 4'd3, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd7};
      vecs[6] = '{4'b1111, 4'b0000, 2'b10, 4'b0000, 1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd8};
      vecs[7] = '{4'b0000, 4'b0000, 2'b10, 4'b0000, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd2, 4'd8};
      vecs[8] = '{4'b0000, 4'b0000, 2'b00, 4'b0000, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd7};

      rst = 1'b1; force_lo = 1'b0;
      in_vld = 4'b1111; in_prt = '0; in_pri = 16'h4321; in_dat = 12'b011_010_001_000;
      deq_req = 2'b11;
      tick();
      check("rst in_rdy", in_rdy, 32'd0);
      check("rst push_1", push_1, 32'd0);
      check("rst push_2", push_2, 32'd0);
      check("rst pop_0", pop_0, 32'd0);
      check("rst deq_vld", deq_vld, 32'd0);
      check("rst occ", occ, 32'd0);
      check("rst err", err, 32'd0);
      rst = 1'b0;

      // Table: arbitration, capacity limit, pop and result path
      for (int i = 0; i < 9; i++) begin
         in_vld = vecs[i].vld; in_prt = vecs[i].prt; deq_req = vecs[i].deq;
         #1;
         check($sformatf("v%0d in_rdy", i), in_rdy, vecs[i].rdy);
         check($sformatf("v%0d push_1", i), push_1, vecs[i].p1);
         check($sformatf("v%0d push_2", i), push_2, vecs[i].p2);
         if (vecs[i].p1) check($sformatf("v%0d upri_1", i), upri_1, vecs[i].pri1);
         if (vecs[i].p2) check($sformatf("v%0d upri_2", i), upri_2, vecs[i].pri2);
         check($sformatf("v%0d pop_0", i), pop_0, vecs[i].pop);
         if (vecs[i].pop) check($sformatf("v%0d oprt_0", i), oprt_0, vecs[i].oprt);
         check($sformatf("v%0d deq_vld", i), deq_vld, vecs[i].dvld);
         if (vecs[i].dvld) check($sformatf("v%0d deq_pri", i), deq_pri, vecs[i].dpri);
         check($sformatf("v%0d occ", i), occ, vecs[i].occ);
         tick();
      end
      check("table err", err, 32'd0);

      // Fill to capacity with every requester asserting
      do_reset();
      in_vld = 4'b1111; in_prt = '0; xfers = 0;
      for (int c = 0; c < 6; c++) begin
         #1;
         xfers += $countones(in_vld & in_rdy);
         tick();
      end
      check("fill xfers", xfers, 32'd8);
      check("fill in_rdy", in_rdy, 32'd0);
      check("fill occ", occ, 32'd8);

      // Rank ordering on one port
      do_reset();
      push0(4'd5, 3'd1);
      push0(4'd2, 3'd2);
      push0(4'd7, 3'd3);
      deq_req = 2'b01; n_res = 0;
      for (int k = 0; k < 8; k++) begin got_pri[k] = 4'hF; got_dat[k] = 3'h7; got_prt[k] = 1'b1; end
      for (int c = 0; c < 8; c++) begin
         #1;
         if (deq_vld && n_res < 8) begin
            got_pri[n_res] = deq_pri; got_dat[n_res] = deq_dat; got_prt[n_res] = deq_prt;
            n_res++;
         end
         tick();
      end
      check("order count", n_res, 32'd3);
      check("order pri0", got_pri[0], 32'd2);
      check("order pri1", got_pri[1], 32'd5);
      check("order pri2", got_pri[2], 32'd7);
      check("order dat0", got_dat[0], 32'd2);
      check("order dat2", got_dat[2], 32'd3);
      check("order prt0", got_prt[0], 32'd0);
      check("order prt2", got_prt[2], 32'd0);
      check("order occ", occ, 32'd0);
      check("order no pop", pop_0, 32'd0);

      // Two ports, two entries each, alternating pops
      do_reset();
      in_vld = 4'b1111; in_prt = 4'b1100; in_pri = 16'h4321;
      #1;
      check("alt lanes0", {push_1, push_2, uprt_1, uprt_2}, 32'b1100);
      tick();
      check("alt lanes1", {push_1, push_2, uprt_1, uprt_2}, 32'b1111);
      tick();
      in_vld = '0; deq_req = 2'b11;
      for (int c = 0; c < 5; c++) begin
         #1;
         pop_seen[c] = pop_0; pop_port[c] = oprt_0;
         tick();
      end
      check("alt pops", {pop_seen[0], pop_seen[1], pop_seen[2], pop_seen[3], pop_seen[4]}, 32'b11110);
      check("alt ports", {pop_port[0], pop_port[1], pop_port[2], pop_port[3]}, 32'b0101);

      // Missing pop result sets a sticky error
      do_reset();
      push0(4'd3, 3'd0);
      deq_req = 2'b01; force_lo = 1'b1;
      #1;
      check("err pop", pop_0, 32'd1);
      tick();
      deq_req = 2'b00;
      check("err deq_vld", deq_vld, 32'd0);
      check("err not yet", err, 32'd0);
      tick();
      force_lo = 1'b0;
      check("err set", err, 32'd1);
      tick(); tick(); tick();
      check("err held", err, 32'd1);
      rst = 1'b1;
      tick();
      check("err cleared", err, 32'd0);
      rst = 1'b0;

      // Reset while a pop result is in flight
      do_reset();
      push0(4'd4, 3'd5);
      deq_req = 2'b01;
      #1;
      check("rsti pop", pop_0, 32'd1);
      tick();
      rst = 1'b1; deq_req = 2'b00;
      #1;
      check("rsti deq_vld", deq_vld, 32'd0);
      tick();
      rst = 1'b0;
      in_vld = 4'b0101; in_prt = 4'b0000; in_pri = 16'h4321; deq_req = 2'b01;
      #1;
      check("rsti occ", occ, 32'd0);
      check("rsti deq_vld2", deq_vld, 32'd0);
      check("rsti err", err, 32'd0);
      check("rsti pop none", pop_0, 32'd0);
      check("rsti grant", {push_1, push_2, upri_1, upri_2}, {24'd0, 2'b11, 4'd1, 4'd3});
      tick();
      in_vld = 4'b0000; deq_req = 2'b00;
      #1;
      check("rsti occ2", occ, 32'd2);
      tick();
      in_vld = 4'b1111;
      #1;
      check("rsti ptr3", {upri_1, upri_2}, {24'd0, 4'd4, 4'd1});
      tick();
      in_vld = '0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
